l2_init_master: RTL
===================

# l2_init_master

AXI4 manager that initializes and optionally verifies a region of the Carfield L2 memory. It runs in the host clock domain and drives the manager side of an L2 port. Its requests reach the L2 wrapper through the existing CDC source, isolation and L2 responder path. On a start request it fills `[base, base+size)` with a 64-bit pattern using INCR write bursts. It pipelines up to `MaxTrans` bursts, tracks responses and reports completion and errors.

## Interface
- `AxiAddrWidth`, 48: AXI address width.
- `AxiDataWidth`, 64: AXI data width; `AxiStrbWidth = AxiDataWidth/8`.
- `AxiIdWidth`, 5: AXI ID width; all transactions use ID 0.
- `AxiUserWidth`, 1: user width; user fields driven 0.
- `BurstLen`, 16: beats per burst, 1..256; `BurstLen*AxiStrbWidth` ≤ 4096.
- `MaxTrans`, 8: maximum outstanding bursts per direction, ≥1.
- `axi_req_t`, `axi_rsp_t`: AXI request/response struct types, matching the L2 port types.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `base_addr_i`  in  AxiAddrWidth  region base; low `log2(BurstLen*AxiStrbWidth)` bits forced to 0.
- `size_i`  in  AxiAddrWidth  region size in bytes; rounded down to a whole number of bursts.
- `pattern_i`  in  AxiDataWidth  fill pattern; latched at start.
- `busy_o`  out  1  high from the cycle after start acceptance until the done pulse.
- `done_o`  out  1  one-cycle completion pulse.
- `error_o`  out  1  sticky; cleared on the next accepted start.
- `axi_req_o`  out  axi_req_t  AXI manager request.
- `axi_rsp_i`  in  axi_rsp_t  AXI manager response.

## Operation
- Burst fields:
  - `len` = BurstLen-1, `size` = log2(AxiStrbWidth), `burst` = INCR.
  - `cache`, `prot`, `qos`, `region`, `atop`, `lock` = 0.
  - W `strb` all ones; W `last` on beat BurstLen-1.
- `nb = size_i / (BurstLen*AxiStrbWidth)`, latched at start. Burst k address = base + k*BurstLen*AxiStrbWidth.
- FSM states: IDLE, WRITE, READ (macro only), FINISH.
- IDLE → WRITE on `start_i`. Latch inputs and clear `error_o`. If nb = 0, go IDLE → FINISH directly.
- WRITE:
  - AW issuer sends bursts while `aw_cnt < nb` and `aw_cnt - b_cnt < MaxTrans`.
  - W issuer sends beats of burst j only when `j < aw_cnt`.
  - B handler always accepts (`bready` = 1). `bresp` ≠ OKAY sets `error_o`.
  - Exit when `b_cnt == nb`, to READ (macro) or FINISH.
- FINISH: `done_o` = 1 for one cycle, then IDLE.
- `start_i` while busy is ignored.
- Counters are `AxiAddrWidth` bits wide; the address adder wraps modulo 2^AxiAddrWidth with no error.

## Timing
- Reset values:
  - `busy_o`, `done_o`, `error_o` = 0.
  - All `*valid` = 0, `bready` = 0, `rready` = 0.
  - Counters 0, state IDLE.
- First `awvalid` in the cycle after start acceptance. First `wvalid` no earlier than the cycle after the AW handshake.
- Once asserted, `awvalid`/`wvalid`/`arvalid` and their payloads stay stable until ready. The valids never depend combinationally on ready.
- AW and W handshakes in the same cycle are both counted. A B arriving in the same cycle as an AW handshake updates both counters; outstanding stays unchanged.
- Throughput: one W beat per cycle under full readiness.
- nb = 0: `done_o` two cycles after start, with no AXI traffic.
- Reset mid-operation drops all valids and returns to IDLE. It is legal only when the downstream path is reset or isolated in the same cycle.

## Configuration
- `L2_INIT_READBACK_EN` defined:
  - After WRITE, enter READ and issue nb AR bursts with the same fields and the same `MaxTrans` limit (`ar_cnt - rb_cnt`).
  - `rready` = 1. Each R beat whose `rdata` ≠ pattern or whose `rresp` ≠ OKAY sets `error_o`.
  - A burst completes on `rlast`. Exit to FINISH when `rb_cnt == nb`.
- Not defined: no READ state and no AR/R logic. `arvalid` and `rready` are tied 0.

## Test plan
- Defaults except BurstLen=4: base 0x7800_0000, size 0x100 → 8 AWs at 0x7800_0000 + 32k, 32 W beats with the pattern, `last` on every 4th beat, `done_o` after the 8th B, `error_o` = 0.
- size 0x10 (less than one burst) → no AXI traffic, `done_o` two cycles after start.
- Responder holds `bvalid` low for 100 cycles → AW stops after exactly 8 bursts outstanding and resumes when B responses return.
- SLVERR on the 3rd B → `error_o` = 1 and stays 1; remaining bursts complete; `done_o` pulses; the next start clears `error_o`.
- With `L2_INIT_READBACK_EN`, responder corrupts one beat of burst 5 → 8 ARs issued, `error_o` = 1 at that beat, `done_o` after the last `rlast`.
- `rst_i` for one cycle during WRITE after 3 AWs → all outputs 0 the next cycle; a new start runs to completion normally.

Source files
------------

// File: rtl/l2_init_master.sv
// AXI4 manager that fills an L2 region with a 64-bit pattern using pipelined INCR bursts.
// Optional read-back verification is enabled by defining L2_INIT_READBACK_EN.

package l2_init_pkg;

  localparam int unsigned AddrWidth = 48;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdWidth   = 5;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } axi_rsp_t;

endpackage

module l2_init_master #(
  parameter int unsigned AxiAddrWidth = 48,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 5,
  parameter int unsigned AxiUserWidth = 1,
  parameter int unsigned BurstLen     = 16,
  parameter int unsigned MaxTrans     = 8,
  parameter type axi_req_t = l2_init_pkg::axi_req_t,
  parameter type axi_rsp_t = l2_init_pkg::axi_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [AxiAddrWidth-1:0] base_addr_i,
  input  logic [AxiAddrWidth-1:0] size_i,
  input  logic [AxiDataWidth-1:0] pattern_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output axi_req_t                axi_req_o,
  input  axi_rsp_t                axi_rsp_i
);

  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;
  // Burst size in bytes is assumed to be a power of two, so division and alignment become shifts/masks.
  localparam int unsigned BurstShift = $clog2(BurstLen * AxiStrbWidth);
  localparam logic [AxiAddrWidth-1:0] BurstBytes = AxiAddrWidth'(BurstLen * AxiStrbWidth);
  localparam logic [AxiAddrWidth-1:0] MaxOut     = AxiAddrWidth'(MaxTrans);
  localparam logic [7:0]              AxiLen     = 8'(BurstLen - 1);
  localparam logic [7:0]              LastBeat   = 8'(BurstLen - 1);
  localparam logic [2:0]              AxiSize    = 3'($clog2(AxiStrbWidth));
  localparam logic [1:0]              BurstIncr  = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
`ifdef L2_INIT_READBACK_EN
    READ   = 2'd2,
`endif
    FINISH = 2'd3
  } state_t;

  state_t                  state;
  logic [AxiAddrWidth-1:0] nb_q;
  logic [AxiDataWidth-1:0] pattern_q;
  logic [AxiAddrWidth-1:0] aw_cnt, b_cnt, w_burst, aw_addr;
  logic [7:0]              w_beat;
  logic                    aw_valid, w_valid, w_last;
  logic                    busy, done, error;

  logic [AxiAddrWidth-1:0] base_aligned, nb_in;
  logic                    aw_hs, w_hs, b_hs;
  logic [AxiAddrWidth-1:0] aw_cnt_n, b_cnt_n, w_burst_n;
  logic [7:0]              w_beat_n;

`ifdef L2_INIT_READBACK_EN
  logic [AxiAddrWidth-1:0] base_q, ar_cnt, rb_cnt, ar_addr;
  logic                    ar_valid;
  logic                    ar_hs, r_hs;
  logic [AxiAddrWidth-1:0] ar_cnt_n, rb_cnt_n;
`endif

  always_comb begin
    base_aligned = base_addr_i & ~(BurstBytes - AxiAddrWidth'(1));
    nb_in        = size_i >> BurstShift;
    aw_hs        = aw_valid & axi_rsp_i.aw_ready;
    w_hs         = w_valid & axi_rsp_i.w_ready;
    b_hs         = (state == WRITE) & axi_rsp_i.b_valid;
    aw_cnt_n     = aw_cnt + AxiAddrWidth'(aw_hs);
    b_cnt_n      = b_cnt + AxiAddrWidth'(b_hs);
    w_burst_n    = w_burst + AxiAddrWidth'(w_hs & w_last);
    w_beat_n     = w_beat;
    if (w_hs) begin
      w_beat_n = w_last ? '0 : w_beat + 8'd1;
    end
`ifdef L2_INIT_READBACK_EN
    ar_hs    = ar_valid & axi_rsp_i.ar_ready;
    r_hs     = (state == READ) & axi_rsp_i.r_valid;
    ar_cnt_n = ar_cnt + AxiAddrWidth'(ar_hs);
    rb_cnt_n = rb_cnt + AxiAddrWidth'(r_hs & axi_rsp_i.r.last);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      nb_q      <= '0;
      pattern_q <= '0;
      aw_cnt    <= '0;
      b_cnt     <= '0;
      w_burst   <= '0;
      aw_addr   <= '0;
      w_beat    <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef L2_INIT_READBACK_EN
      base_q    <= '0;
      ar_cnt    <= '0;
      rb_cnt    <= '0;
      ar_addr   <= '0;
      ar_valid  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            nb_q      <= nb_in;
            pattern_q <= pattern_i;
            error     <= 1'b0;
            busy      <= 1'b1;
            aw_cnt    <= '0;
            b_cnt     <= '0;
            w_burst   <= '0;
            w_beat    <= '0;
            aw_addr   <= base_aligned;
`ifdef L2_INIT_READBACK_EN
            base_q    <= base_aligned;
`endif
            if (nb_in == '0) begin
              state <= FINISH;
            end else begin
              state    <= WRITE;
              aw_valid <= 1'b1;
            end
          end
        end

        WRITE: begin
          aw_cnt  <= aw_cnt_n;
          b_cnt   <= b_cnt_n;
          w_burst <= w_burst_n;
          w_beat  <= w_beat_n;
          // Next valid/payload are decided only when the current beat is gone, keeping them stable until ready.
          if (!aw_valid || aw_hs) begin
            aw_valid <= (aw_cnt_n < nb_q) && ((aw_cnt_n - b_cnt_n) < MaxOut);
          end
          if (aw_hs) begin
            aw_addr <= aw_addr + BurstBytes;
          end
          if (!w_valid || w_hs) begin
            w_valid <= w_burst_n < aw_cnt_n;
            w_last  <= w_beat_n == LastBeat;
          end
          if (b_hs && (axi_rsp_i.b.resp != 2'b00)) begin
            error <= 1'b1;
          end
          if (b_cnt_n == nb_q) begin
`ifdef L2_INIT_READBACK_EN
            state    <= READ;
            ar_cnt   <= '0;
            rb_cnt   <= '0;
            ar_addr  <= base_q;
            ar_valid <= 1'b1;
`else
            state    <= FINISH;
`endif
          end
        end

`ifdef L2_INIT_READBACK_EN
        READ: begin
          ar_cnt <= ar_cnt_n;
          rb_cnt <= rb_cnt_n;
          if (!ar_valid || ar_hs) begin
            ar_valid <= (ar_cnt_n < nb_q) && ((ar_cnt_n - rb_cnt_n) < MaxOut);
          end
          if (ar_hs) begin
            ar_addr <= ar_addr + BurstBytes;
          end
          if (r_hs && ((axi_rsp_i.r.data != pattern_q) || (axi_rsp_i.r.resp != 2'b00))) begin
            error <= 1'b1;
          end
          if (rb_cnt_n == nb_q) begin
            state <= FINISH;
          end
        end
`endif

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_req_o            = '0;
    axi_req_o.aw.id      = {AxiIdWidth{1'b0}};
    axi_req_o.aw.addr    = aw_addr;
    axi_req_o.aw.len     = AxiLen;
    axi_req_o.aw.size    = AxiSize;
    axi_req_o.aw.burst   = BurstIncr;
    axi_req_o.aw.user    = {AxiUserWidth{1'b0}};
    axi_req_o.aw_valid   = aw_valid;
    axi_req_o.w.data     = pattern_q;
    axi_req_o.w.strb     = {AxiStrbWidth{1'b1}};
    axi_req_o.w.last     = w_last;
    axi_req_o.w.user     = {AxiUserWidth{1'b0}};
    axi_req_o.w_valid    = w_valid;
    axi_req_o.b_ready    = (state == WRITE);
`ifdef L2_INIT_READBACK_EN
    axi_req_o.ar.id      = {AxiIdWidth{1'b0}};
    axi_req_o.ar.addr    = ar_addr;
    axi_req_o.ar.len     = AxiLen;
    axi_req_o.ar.size    = AxiSize;
    axi_req_o.ar.burst   = BurstIncr;
    axi_req_o.ar.user    = {AxiUserWidth{1'b0}};
    axi_req_o.ar_valid   = ar_valid;
    axi_req_o.r_ready    = (state == READ);
`endif
  end

  assign busy_o  = busy;
  assign done_o  = done;
  assign error_o = error;

  // IDs, user bits and (without read-back) the whole read side of the response are ignored.
  logic unused_rsp;
  assign unused_rsp = ^axi_rsp_i;

endmodule
